// File: rtl/pl_hazard_pkg.sv
// Shared encodings and FSM state type for the pipeline hazard / forwarding controller.
package pl_hazard_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pl_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pl_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic [4:0]       RdM;
    logic             RegWriteM;
    logic             MemReqM;
    logic             MemReadyM;
    logic [4:0]       RdW;
    logic             RegWriteW;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pl_fwd_sel.sv
// Forwarding select for one execute-stage ALU operand; M result wins over W result.
module pl_fwd_sel
    import pl_hazard_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic       i_reg_write_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_w,
    output logic [1:0] o_fwd
);

    always_comb begin
        o_fwd = FWD_RF;
        if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs)) begin
            o_fwd = FWD_M;
        end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs)) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller with data-memory wait timeout FSM.
// Optional performance counters are built when PL_HAZARD_PERF_CNT_EN is defined.
module pl_hazard_ctrl
    import pl_hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    pl_hazard_ctrl_if.slave hz
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    hz_state_e  r_state, w_state_next;
    logic [7:0] r_wcnt, w_wcnt_next;
    logic       r_mem_err;

    logic       w_mem_hold, w_lw_stall, w_hold_all, w_fwd_zero;
    logic [1:0] w_fwd_a, w_fwd_b;
    logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic       w_flush_d, w_flush_e, w_flush_w;
    logic [1:0] w_fwd_ae, w_fwd_be;

    pl_fwd_sel u_fwd_a (
        .i_rs          (hz.Rs1E),
        .i_rd_m        (hz.RdM),
        .i_reg_write_m (hz.RegWriteM),
        .i_rd_w        (hz.RdW),
        .i_reg_write_w (hz.RegWriteW),
        .o_fwd         (w_fwd_a)
    );

    pl_fwd_sel u_fwd_b (
        .i_rs          (hz.Rs2E),
        .i_rd_m        (hz.RdM),
        .i_reg_write_m (hz.RegWriteM),
        .i_rd_w        (hz.RdW),
        .i_reg_write_w (hz.RegWriteW),
        .o_fwd         (w_fwd_b)
    );

    assign w_mem_hold = hz.MemReqM && !hz.MemReadyM;
    assign w_lw_stall = (hz.ResultSrcE == RES_LOAD) && (hz.RdE != 5'd0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Next-state logic; w_hold_all freezes every stage and bubbles W.
    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_hold_all   = 1'b0;
        w_fwd_zero   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_hold) begin
                    w_hold_all   = 1'b1;
                    w_state_next = MEM_WAIT;
                    w_wcnt_next  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (w_mem_hold) begin
                    w_hold_all  = 1'b1;
                    w_wcnt_next = r_wcnt + 8'd1;
                    if (r_wcnt == TIMEOUT_CNT) begin
                        w_state_next = ERR;
                    end
                end else begin
                    w_state_next = RUN;
                    w_wcnt_next  = 8'd0;
                end
            end
            ERR: begin
                w_hold_all = 1'b1;
                w_fwd_zero = 1'b1;
            end
            default: begin
                w_state_next = RUN;
                w_wcnt_next  = 8'd0;
            end
        endcase
    end

    // Reset is folded in combinationally so the unreset pipeline registers clear at once.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        w_fwd_ae  = w_fwd_a;
        w_fwd_be  = w_fwd_b;
        if (!rst_n) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_flush_w = 1'b1;
            w_fwd_ae  = FWD_RF;
            w_fwd_be  = FWD_RF;
        end else if (w_hold_all) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
            if (w_fwd_zero) begin
                w_fwd_ae = FWD_RF;
                w_fwd_be = FWD_RF;
            end
        end else begin
            w_stall_f = w_lw_stall;
            w_stall_d = w_lw_stall;
            w_flush_d = hz.PCSrcE;
            w_flush_e = w_lw_stall | hz.PCSrcE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_wcnt    <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_wcnt    <= w_wcnt_next;
            r_mem_err <= (w_state_next == ERR);
        end
    end

    assign hz.StallF    = w_stall_f;
    assign hz.StallD    = w_stall_d;
    assign hz.StallE    = w_stall_e;
    assign hz.StallM    = w_stall_m;
    assign hz.FlushD    = w_flush_d;
    assign hz.FlushE    = w_flush_e;
    assign hz.FlushW    = w_flush_w;
    assign hz.ForwardAE = w_fwd_ae;
    assign hz.ForwardBE = w_fwd_be;
    assign hz.mem_err   = r_mem_err;

`ifdef PL_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((w_flush_d || w_flush_e) && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed plus randomized bench for pl_hazard_ctrl against a behavioural model.
module tb_pl_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pl_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pl_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int errors = 0;
    int checks = 0;

    // Model: consecutive memory-hold cycles seen, sticky error, counters.
    int          m_hold_run;
    bit          m_err;
    longint      m_stall_cnt, m_flush_cnt;
    bit          last_stall_f, last_flush_de, last_mem_hold;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (hz.RegWriteM && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_hold_run  = 0;
        m_err       = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic compare_outputs(string ctx);
        logic [3:0] e_stall;
        logic [2:0] e_flush;
        logic [1:0] ea, eb;
        bit lw, mh;
        lw = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
             ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        mh = hz.MemReqM && !hz.MemReadyM;
        ea = ref_fwd(hz.Rs1E);
        eb = ref_fwd(hz.Rs2E);
        if (!rst_n) begin
            e_stall = 4'b0000; e_flush = 3'b111; ea = 2'b00; eb = 2'b00;
        end else if (m_err) begin
            e_stall = 4'b1111; e_flush = 3'b001; ea = 2'b00; eb = 2'b00;
        end else if (mh) begin
            e_stall = 4'b1111; e_flush = 3'b001;
        end else begin
            e_stall = {lw, lw, 2'b00};
            e_flush = {hz.PCSrcE, lw | hz.PCSrcE, 1'b0};
        end
        last_stall_f  = e_stall[3];
        last_flush_de = e_flush[2] | e_flush[1];
        last_mem_hold = mh;
        check({ctx, ".stall"}, 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'(e_stall));
        check({ctx, ".flush"}, 32'({hz.FlushD, hz.FlushE, hz.FlushW}), 32'(e_flush));
        check({ctx, ".fwdA"}, 32'(hz.ForwardAE), 32'(ea));
        check({ctx, ".fwdB"}, 32'(hz.ForwardBE), 32'(eb));
        check({ctx, ".mem_err"}, 32'(hz.mem_err), 32'(m_err));
`ifdef PL_HAZARD_PERF_CNT_EN
        check({ctx, ".stall_cnt"}, hz.stall_cnt, 32'(m_stall_cnt));
        check({ctx, ".flush_cnt"}, hz.flush_cnt, 32'(m_flush_cnt));
`else
        check({ctx, ".stall_cnt"}, hz.stall_cnt, 32'd0);
        check({ctx, ".flush_cnt"}, hz.flush_cnt, 32'd0);
`endif
    endtask

    task automatic model_update();
        if (last_stall_f)  m_stall_cnt++;
        if (last_flush_de) m_flush_cnt++;
        if (!m_err) begin
            if (last_mem_hold) begin
                m_hold_run++;
                if (m_hold_run > TO) m_err = 1'b1;
            end else begin
                m_hold_run = 0;
            end
        end
    endtask

    // Inputs are already applied; check mid-cycle, then let the edge happen.
    task automatic cycle(string ctx);
        @(negedge clk);
        #1;
        compare_outputs(ctx);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulse_reset(string ctx);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_outputs({ctx, ".async"});
        @(negedge clk);
        #1;
        compare_outputs({ctx, ".held"});
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        compare_outputs({ctx, ".post"});
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
        hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
        hz.RdM = '0; hz.RegWriteM = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
        hz.RdW = '0; hz.RegWriteW = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_outputs("reset0");
        @(posedge clk);
        #1;
        pulse_reset("reset1");

        // Forwarding priority
        hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5;
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
        cycle("fwd_m");
        hz.RdM = 5'd0;
        cycle("fwd_w");
        hz.Rs1E = 5'd0; hz.RdW = 5'd0;
        cycle("fwd_rf");
        hz.RdW = 5'd9; hz.Rs2E = 5'd9; hz.RdM = 5'd5; hz.Rs1E = 5'd5;
        cycle("fwd_mix");

        // Load-use, then clear
        idle();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        cycle("loaduse");
        hz.ResultSrcE = 2'b00;
        cycle("loaduse_clr");
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
        cycle("loaduse_x0");

        // Taken branch
        idle();
        hz.PCSrcE = 1'b1;
        cycle("branch");
        hz.PCSrcE = 1'b0;
        cycle("branch_clr");

        // Memory wait of 3 cycles with a taken branch held in E
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0; hz.PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) cycle($sformatf("memwait%0d", i));
        hz.MemReadyM = 1'b1;
        cycle("mem_release");
        idle();
        cycle("mem_after");

        // Longest wait that still releases cleanly
        hz.MemReqM = 1'b1;
        for (int i = 0; i < TO; i++) cycle($sformatf("memlimit%0d", i));
        hz.MemReadyM = 1'b1;
        cycle("memlimit_release");
        idle();
        cycle("memlimit_after");
        check("no_err_at_limit", 32'(hz.mem_err), 32'd0);

        // Two load-use stalls for the counters
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
        cycle("lu_a");
        cycle("lu_b");
        idle();

        // Timeout into ERR, then stuck until reset
        hz.MemReqM = 1'b1;
        for (int i = 0; i < TO + 4; i++) cycle($sformatf("timeout%0d", i));
        check("err_sticky", 32'(hz.mem_err), 32'd1);
        hz.MemReadyM = 1'b1; hz.PCSrcE = 1'b1;
        cycle("err_ignores_ready");
        pulse_reset("reset_err");
        idle();
        cycle("after_err_reset");

        // Reset in the middle of a wait
        hz.MemReqM = 1'b1;
        cycle("midwait0");
        cycle("midwait1");
        pulse_reset("reset_midwait");
        idle();
        cycle("midwait_after");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            hz.Rs1D = 5'($urandom_range(0, 3));
            hz.Rs2D = 5'($urandom_range(0, 3));
            hz.Rs1E = 5'($urandom_range(0, 3));
            hz.Rs2E = 5'($urandom_range(0, 3));
            hz.RdE  = 5'($urandom_range(0, 3));
            hz.RdM  = 5'($urandom_range(0, 3));
            hz.RdW  = 5'($urandom_range(0, 3));
            hz.RegWriteM  = 1'($urandom_range(0, 1));
            hz.RegWriteW  = 1'($urandom_range(0, 1));
            hz.ResultSrcE = 2'($urandom_range(0, 3));
            hz.PCSrcE     = ($urandom_range(0, 3) == 0);
            hz.MemReqM    = ($urandom_range(0, 2) == 0) || (n >= 300 && n < 340);
            hz.MemReadyM  = (n >= 300 && n < 340) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 79) == 0 || n == 350) begin
                pulse_reset($sformatf("rnd_reset%0d", n));
            end else begin
                cycle($sformatf("rnd%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
